// File: rtl/fpdiv_pkg.sv
// Shared types and constants for the Newton-Raphson floating-point divider.
// Builder functions return 64-bit words; callers size-cast to their own format width.
package fpdiv_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SEED,
    ST_ITER_A,
    ST_ITER_B,
    ST_QMUL,
    ST_ROUND,
    ST_DONE
  } state_t;

  localparam logic [1:0] EXC_NONE    = 2'b00;
  localparam logic [1:0] EXC_INVALID = 2'b01;
  localparam logic [1:0] EXC_DIVZERO = 2'b10;
  localparam logic [1:0] EXC_RANGE   = 2'b11;

  // Seed line X0 = 48/17 - 32/17*D, as fixed point with f fraction bits.
  function automatic logic [63:0] c48_17(input int f);
    return (64'd48 << f) / 64'd17;
  endfunction

  function automatic logic [63:0] c32_17(input int f);
    return (64'd32 << f) / 64'd17;
  endfunction

  function automatic logic [63:0] fp_inf(input int exp_w, input int frac_w, input logic sign);
    return (64'(sign) << (exp_w + frac_w)) | (((64'd1 << exp_w) - 64'd1) << frac_w);
  endfunction

  function automatic logic [63:0] fp_zero(input int exp_w, input int frac_w, input logic sign);
    return 64'(sign) << (exp_w + frac_w);
  endfunction

  function automatic logic [63:0] fp_qnan(input int exp_w, input int frac_w);
    return fp_inf(exp_w, frac_w, 1'b0) | (64'd1 << (frac_w - 1));
  endfunction

endpackage

// File: rtl/fpdiv_classify.sv
// Operand classifier: zero (subnormals flushed), infinity, NaN and the hidden-bit mantissa.
module fpdiv_classify #(
  parameter int EXP_W  = 8,
  parameter int FRAC_W = 23
) (
  input  logic [EXP_W+FRAC_W-1:0] mag,
  output logic                    is_zero,
  output logic                    is_inf,
  output logic                    is_nan,
  output logic [FRAC_W:0]         mant
);

  logic [EXP_W-1:0]  exp_f;
  logic [FRAC_W-1:0] frac_f;

  assign exp_f   = mag[EXP_W+FRAC_W-1:FRAC_W];
  assign frac_f  = mag[FRAC_W-1:0];
  assign is_zero = (exp_f == '0);
  assign is_inf  = (&exp_f) && (frac_f == '0);
  assign is_nan  = (&exp_f) && (frac_f != '0);
  assign mant    = {1'b1, frac_f};

endmodule

// File: rtl/fpdiv_nr_pipe_ctrl.sv
// Multi-cycle floating-point divider: Newton-Raphson reciprocal of mB/2, then one multiply by mA.
// A single shared fixed-point multiplier and subtractor are sequenced by the FSM.
module fpdiv_nr_pipe_ctrl
  import fpdiv_pkg::*;
#(
  parameter int EXP_W    = 8,
  parameter int FRAC_W   = 23,
  parameter int NR_ITERS = 3,
  parameter int GUARD    = 6
) (
  input  logic                    CLOCK,
  input  logic                    RESET,
  input  logic [EXP_W+FRAC_W:0]   InputA,
  input  logic [EXP_W+FRAC_W:0]   InputB,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [EXP_W+FRAC_W:0]   AbyB,
  output logic [1:0]              EXCEPTION,
  output logic                    DONE,
  input  logic                    out_ready
);

  localparam int N  = 1 + EXP_W + FRAC_W;
  localparam int F  = FRAC_W + 1 + GUARD;
  localparam int W  = F + 2;
  localparam int EW = EXP_W + 2;

  localparam logic [W-1:0]         C48       = W'(c48_17(F));
  localparam logic [W-1:0]         C32       = W'(c32_17(F));
  localparam logic [W-1:0]         TWO       = W'(64'd2 << F);
  localparam logic signed [EW-1:0] BIAS_M1   = EW'((2 ** (EXP_W - 1)) - 2);
  localparam logic signed [EW-1:0] E_MAX     = EW'((2 ** EXP_W) - 1);
  localparam logic signed [EW-1:0] E_ZERO    = '0;
  localparam logic [2:0]           LAST_ITER = 3'(NR_ITERS - 1);
  localparam logic [N-1:0]         QNAN      = N'(fp_qnan(EXP_W, FRAC_W));

  state_t                 state;
  logic [2:0]             iter_cnt;
  logic [FRAC_W:0]        ma_reg, mb_reg;
  logic [W-1:0]           x_reg, t_reg, q_reg;
  logic signed [EW-1:0]   e_reg;
  logic                   s_reg;

  logic                   a_zero, a_inf, a_nan, b_zero, b_inf, b_nan;
  logic [FRAC_W:0]        a_mant, b_mant;
  logic                   sign_in;

  fpdiv_classify #(.EXP_W(EXP_W), .FRAC_W(FRAC_W)) u_cls_a (
    .mag(InputA[N-2:0]), .is_zero(a_zero), .is_inf(a_inf), .is_nan(a_nan), .mant(a_mant)
  );
  fpdiv_classify #(.EXP_W(EXP_W), .FRAC_W(FRAC_W)) u_cls_b (
    .mag(InputB[N-2:0]), .is_zero(b_zero), .is_inf(b_inf), .is_nan(b_nan), .mant(b_mant)
  );

  assign sign_in  = InputA[N-1] ^ InputB[N-1];
  assign in_ready = (state == ST_IDLE) && !RESET;

  // Special operands resolve at accept time in priority order.
  logic           spec_hit;
  logic [N-1:0]   spec_word;
  logic [1:0]     spec_exc;

  always_comb begin
    spec_hit  = 1'b1;
    spec_word = QNAN;
    spec_exc  = EXC_NONE;
    if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) begin
      spec_exc = EXC_INVALID;
    end else if (a_inf) begin
      spec_word = N'(fp_inf(EXP_W, FRAC_W, sign_in));
    end else if (b_zero) begin
      spec_word = N'(fp_inf(EXP_W, FRAC_W, sign_in));
      spec_exc  = EXC_DIVZERO;
    end else if (a_zero || b_inf) begin
      spec_word = N'(fp_zero(EXP_W, FRAC_W, sign_in));
    end else begin
      spec_hit = 1'b0;
    end
  end

  logic [W-1:0]   ma_fx, d_fx, mul_a, mul_b, mul_res, sub_res;
  logic [2*W-1:0] prod;

  assign ma_fx = W'({ma_reg, {(GUARD + 1){1'b0}}});
  assign d_fx  = W'({mb_reg, {GUARD{1'b0}}});

  always_comb begin
    mul_a = d_fx;
    mul_b = C32;
    case (state)
      ST_ITER_A: begin mul_a = d_fx;   mul_b = x_reg; end
      ST_ITER_B: begin mul_a = x_reg;  mul_b = t_reg; end
      ST_QMUL:   begin mul_a = ma_fx;  mul_b = x_reg; end
      default:   ;
    endcase
  end

  // Products are truncated back to F fraction bits.
  assign prod    = {{W{1'b0}}, mul_a} * {{W{1'b0}}, mul_b};
  assign mul_res = W'(prod >> F);
  assign sub_res = ((state == ST_SEED) ? C48 : TWO) - mul_res;

  logic [W-1:0]         qn;
  logic [FRAC_W:0]      kept;
  logic [FRAC_W+1:0]    rsum;
  logic [FRAC_W-1:0]    rfrac;
  logic signed [EW-1:0] e_fin;
  logic [N-1:0]         round_word;
  logic [1:0]           round_exc;

  always_comb begin
    qn    = q_reg[W-1] ? (q_reg >> 1) : q_reg;
    kept  = (FRAC_W + 1)'(qn >> (GUARD + 1));
    rsum  = {1'b0, kept} + (FRAC_W + 2)'(qn[GUARD]);
    rfrac = rsum[FRAC_W+1] ? rsum[FRAC_W:1] : rsum[FRAC_W-1:0];
    e_fin = e_reg + $signed(EW'(q_reg[W-1])) + $signed(EW'(rsum[FRAC_W+1]));
    round_word = {s_reg, e_fin[EXP_W-1:0], rfrac};
    round_exc  = EXC_NONE;
    if (e_fin >= E_MAX) begin
      round_word = N'(fp_inf(EXP_W, FRAC_W, s_reg));
      round_exc  = EXC_RANGE;
    end else if (e_fin <= E_ZERO) begin
      round_word = N'(fp_zero(EXP_W, FRAC_W, s_reg));
      round_exc  = EXC_RANGE;
    end
  end

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      state     <= ST_IDLE;
      iter_cnt  <= '0;
      AbyB      <= '0;
      EXCEPTION <= EXC_NONE;
      DONE      <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: if (in_valid) begin
          if (spec_hit) begin
            AbyB      <= spec_word;
            EXCEPTION <= spec_exc;
            DONE      <= 1'b1;
            state     <= ST_DONE;
          end else begin
            ma_reg <= a_mant;
            mb_reg <= b_mant;
            s_reg  <= sign_in;
            e_reg  <= $signed({2'b00, InputA[N-2:FRAC_W]}) - $signed({2'b00, InputB[N-2:FRAC_W]}) + BIAS_M1;
            state  <= ST_SEED;
          end
        end
        ST_SEED: begin
          x_reg    <= sub_res;
          iter_cnt <= '0;
          state    <= ST_ITER_A;
        end
        ST_ITER_A: begin
          t_reg <= sub_res;
          state <= ST_ITER_B;
        end
        ST_ITER_B: begin
          x_reg <= mul_res;
          if (iter_cnt == LAST_ITER) begin
            state <= ST_QMUL;
          end else begin
            iter_cnt <= iter_cnt + 3'd1;
            state    <= ST_ITER_A;
          end
        end
        ST_QMUL: begin
          q_reg <= mul_res;
          state <= ST_ROUND;
        end
        ST_ROUND: begin
          AbyB      <= round_word;
          EXCEPTION <= round_exc;
          DONE      <= 1'b1;
          state     <= ST_DONE;
        end
        ST_DONE: if (out_ready) begin
          DONE  <= 1'b0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fpdiv_nr_pipe_ctrl.sv
// Bench for fpdiv_nr_pipe_ctrl (FP32 defaults): directed special/range/handshake cases plus
// random operands checked against real-number division rounded to the nearest FP32 value.
module tb_fpdiv_nr_pipe_ctrl;

  logic        CLOCK = 1'b0;
  logic        RESET;
  logic [31:0] InputA, InputB;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] AbyB;
  logic [1:0]  EXCEPTION;
  logic        DONE;
  logic        out_ready;

  int n_cmp = 0;
  int n_bad = 0;

  localparam int NORM_LAT = 2 * 3 + 3;

  always #5 CLOCK = ~CLOCK;

  fpdiv_nr_pipe_ctrl dut (
    .CLOCK(CLOCK), .RESET(RESET), .InputA(InputA), .InputB(InputB),
    .in_valid(in_valid), .in_ready(in_ready), .AbyB(AbyB),
    .EXCEPTION(EXCEPTION), .DONE(DONE), .out_ready(out_ready)
  );

  task automatic check(input string tag, input longint got, input longint exp, input longint tol = 0);
    longint d;
    n_cmp++;
    d = (got > exp) ? got - exp : exp - got;
    if (d > tol) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (tolerance %0d)", tag, got, exp, tol);
    end
  endtask

  // Normal FP32 operand to exact double.
  function automatic real f2r(input logic [31:0] f);
    logic [10:0] e11;
    e11 = {3'b000, f[30:23]} + 11'd896;
    return $bitstoreal({f[31], e11, f[22:0], 29'd0});
  endfunction

  // Quotient of two normals, rounded to nearest FP32 (result assumed in normal range).
  function automatic logic [31:0] ref_div(input logic [31:0] a, input logic [31:0] b);
    real         q;
    logic [63:0] db;
    logic [10:0] fe;
    logic [30:0] mag;
    q   = f2r(a) / f2r(b);
    db  = $realtobits(q);
    fe  = db[62:52] - 11'd896;
    mag = {fe[7:0], db[51:29]} + {30'd0, db[28]};
    return {db[63], mag};
  endfunction

  // Result for operand pairs involving zero, infinity or NaN.
  function automatic void ref_special(input logic [31:0] a, input logic [31:0] b,
                                      output logic [31:0] q, output logic [1:0] exc);
    logic za, zb, ia, ib, na, nb, s;
    za = (a[30:23] == 8'h00);
    zb = (b[30:23] == 8'h00);
    ia = (a[30:23] == 8'hFF) && (a[22:0] == 0);
    ib = (b[30:23] == 8'hFF) && (b[22:0] == 0);
    na = (a[30:23] == 8'hFF) && (a[22:0] != 0);
    nb = (b[30:23] == 8'hFF) && (b[22:0] != 0);
    s  = a[31] ^ b[31];
    q = {s, 31'd0};
    exc = 2'd0;
    if (na || nb || (za && zb) || (ia && ib)) begin
      q = 32'h7FC00000; exc = 2'd1;
    end else if (ia) begin
      q = {s, 8'hFF, 23'd0};
    end else if (zb) begin
      q = {s, 8'hFF, 23'd0}; exc = 2'd2;
    end
  endfunction

  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp_q,
                        input logic [1:0] exp_exc, input int tol, input int exp_lat,
                        input int hold, input string tag);
    int w;
    int lat;
    out_ready = (hold == 0);
    w = 0;
    while (!in_ready && w < 30) begin @(posedge CLOCK); #1; w++; end
    check({tag, "_rdy"}, in_ready, 1);
    InputA = a; InputB = b; in_valid = 1'b1;
    @(posedge CLOCK); #1;
    in_valid = 1'b0;
    InputA = $urandom; InputB = $urandom;
    lat = 0;
    while (!DONE && lat < 40) begin @(posedge CLOCK); #1; lat++; end
    check({tag, "_lat"}, lat, exp_lat);
    check({tag, "_q"}, AbyB, exp_q, tol);
    check({tag, "_exc"}, EXCEPTION, exp_exc);
    $display("op %s a=%h b=%h q=%h exp=%h exc=%0d lat=%0d", tag, a, b, AbyB, exp_q, EXCEPTION, lat);
    if (hold > 0) begin
      repeat (hold) begin @(posedge CLOCK); #1; end
      check({tag, "_hold_done"}, DONE, 1);
      check({tag, "_hold_q"}, AbyB, exp_q, tol);
      check({tag, "_hold_rdy"}, in_ready, 0);
      out_ready = 1'b1;
    end
    @(posedge CLOCK); #1;
    check({tag, "_release"}, DONE, 0);
    out_ready = 1'b0;
  endtask

  initial begin
    logic [31:0] a, b, q;
    logic [1:0]  exc;
    int          seen;

    RESET = 1'b1; in_valid = 1'b0; out_ready = 1'b0; InputA = '0; InputB = '0;
    repeat (3) begin @(posedge CLOCK); #1; end
    check("rst_q", AbyB, 0);
    check("rst_exc", EXCEPTION, 0);
    check("rst_done", DONE, 0);
    check("rst_rdy", in_ready, 0);
    RESET = 1'b0; #1;
    check("rst_rdy_after", in_ready, 1);

    run_op(32'h40A00000, 32'h40000000, 32'h40200000, 2'd0, 1, NORM_LAT, 0, "5div2");
    run_op(32'h40000000, 32'h00000000, 32'h7F800000, 2'd2, 0, 0, 0, "2div0");
    run_op(32'h00000000, 32'h00000000, 32'h7FC00000, 2'd1, 0, 0, 0, "0div0");
    run_op(32'h7F800000, 32'h7F800000, 32'h7FC00000, 2'd1, 0, 0, 0, "infdivinf");
    run_op(32'h40000000, 32'h7F800000, 32'h00000000, 2'd0, 0, 0, 0, "2divinf");
    run_op(32'hC0C00000, 32'h40400000, 32'hC0000000, 2'd0, 1, NORM_LAT, 0, "m6div3");
    run_op(32'h7F7FFFFF, 32'h00800000, 32'h7F800000, 2'd3, 0, NORM_LAT, 0, "ovf");
    run_op(32'h00800000, 32'h7F7FFFFF, 32'h00000000, 2'd3, 0, NORM_LAT, 0, "unf");
    run_op(32'h7FC00001, 32'h3F800000, 32'h7FC00000, 2'd1, 0, 0, 0, "nan");
    run_op(32'hFF800000, 32'h40000000, 32'hFF800000, 2'd0, 0, 0, 0, "ninfdiv2");
    run_op(32'hC0000000, 32'h80000000, 32'h7F800000, 2'd2, 0, 0, 0, "m2divm0");
    run_op(32'h00000001, 32'h3F800000, 32'h00000000, 2'd0, 0, 0, 0, "subnorm");
    run_op(32'h40A00000, 32'h40000000, 32'h40200000, 2'd0, 1, NORM_LAT, 10, "hold");

    // Reset while the iteration is in flight: no result may surface afterwards.
    InputA = 32'h40A00000; InputB = 32'h40000000; in_valid = 1'b1;
    @(posedge CLOCK); #1;
    in_valid = 1'b0;
    repeat (2) begin @(posedge CLOCK); #1; end
    RESET = 1'b1;
    @(posedge CLOCK); #1;
    check("abort_rdy_in_rst", in_ready, 0);
    check("abort_done", DONE, 0);
    RESET = 1'b0; #1;
    check("abort_rdy", in_ready, 1);
    seen = 0;
    repeat (12) begin @(posedge CLOCK); #1; if (DONE) seen++; end
    check("abort_stale", seen, 0);
    run_op(32'h3F800000, 32'h40000000, 32'h3F000000, 2'd0, 1, NORM_LAT, 0, "after_abort");

    for (int i = 0; i < 1500; i++) begin
      a = {1'($urandom), 8'($urandom_range(80, 175)), 23'($urandom)};
      b = {1'($urandom), 8'($urandom_range(80, 175)), 23'($urandom)};
      run_op(a, b, ref_div(a, b), 2'd0, 1, NORM_LAT, ($urandom_range(0, 15) == 0) ? 2 : 0, "rnd");
    end

    for (int i = 0; i < 200; i++) begin
      a = $urandom; b = $urandom;
      case ($urandom_range(0, 2))
        0: b[30:23] = 8'h00;
        1: b[30:23] = 8'hFF;
        default: a[30:23] = ($urandom_range(0, 1) == 0) ? 8'h00 : 8'hFF;
      endcase
      if (a[30:23] == 8'hFF && $urandom_range(0, 1) == 0) a[22:0] = '0;
      if (b[30:23] == 8'hFF && $urandom_range(0, 1) == 0) b[22:0] = '0;
      ref_special(a, b, q, exc);
      run_op(a, b, q, exc, 0, 0, 0, "rnd_spec");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
